// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer slice.
package phase_sequencer_pkg;

    // Halt request bus width used across the core
    localparam int HALTBUSWIDTH = 2;

    typedef enum logic [2:0] {
        PSEQ_RESET_HOLD = 3'd0,
        PSEQ_START_WAIT = 3'd1,
        PSEQ_RUN        = 3'd2,
        PSEQ_STEP       = 3'd3,
        PSEQ_HALTED     = 3'd4
    } pseq_state_t;

    // True for states with no train in flight
    function automatic logic is_idle(input pseq_state_t s);
        return (s == PSEQ_RESET_HOLD) || (s == PSEQ_START_WAIT) || (s == PSEQ_HALTED);
    endfunction

endpackage

// File: rtl/phase_sequencer_ring.sv
// One-hot phase rotator: clear has priority over load0, otherwise rotates left by one.
module phase_ring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load0,
    input  logic         clear,
    output logic [N-1:0] q,
    output logic         last
);

    // Rotate the token; an all-zero ring stays all-zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load0) begin
            q <= N'(1);
        end else begin
            q <= (q << 1) | (q >> (N - 1));
        end
    end

    assign last = q[N-1];

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: reset release, start delay, one-hot phase trains with
// boundary-aligned halt and single-train step.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int PHASES       = 4,
    parameter int RESET_CYCLES = 3,
    parameter int START_CYCLES = 4,
    parameter int HALTW        = HALTBUSWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [HALTW-1:0]  halt_req,
    input  logic              step,
    output logic              core_reset_n,
    output logic [PHASES-1:0] ph_en,
    output logic              train_start,
    output logic              halted,
    output logic [31:0]       train_count
);

    localparam int DW = $clog2(START_CYCLES + 1);
    localparam logic [DW-1:0] RESET_PRE = DW'(RESET_CYCLES - 1);
    localparam logic [DW-1:0] START_PRE = DW'(START_CYCLES - 1);
    localparam logic [DW-1:0] DLY_MAX   = DW'(START_CYCLES);

    pseq_state_t   state;
    pseq_state_t   state_next;
    logic [DW-1:0] dly;
    logic          load0;
    logic          clear;
    logic          last;
    logic          halt_any;

    assign halt_any = |halt_req;

    phase_ring #(.N(PHASES)) u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .load0   (load0),
        .clear   (clear),
        .q       (ph_en),
        .last    (last)
    );

    // Next-state and ring control; halt is only looked at on the last phase
    always_comb begin
        state_next = state;
        load0      = 1'b0;
        clear      = 1'b0;
        case (state)
            PSEQ_RESET_HOLD: begin
                if (dly == RESET_PRE) state_next = PSEQ_START_WAIT;
            end
            PSEQ_START_WAIT: begin
                if (dly == START_PRE) begin
                    if (halt_any) begin
                        state_next = PSEQ_HALTED;
                    end else begin
                        state_next = PSEQ_RUN;
                        load0      = 1'b1;
                    end
                end
            end
            PSEQ_RUN, PSEQ_STEP: begin
                if (last) begin
                    if (halt_any) begin
                        state_next = PSEQ_HALTED;
                        clear      = 1'b1;
                    end else begin
                        state_next = PSEQ_RUN;
                    end
                end
            end
            PSEQ_HALTED: begin
                if (!halt_any) begin
                    state_next = PSEQ_RUN;
                    load0      = 1'b1;
                end else if (step) begin
                    state_next = PSEQ_STEP;
                    load0      = 1'b1;
                end
            end
            default: state_next = PSEQ_RESET_HOLD;
        endcase
    end

    // State, delay counter and registered outputs; train_start mirrors the ring's next bit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PSEQ_RESET_HOLD;
            dly          <= '0;
            core_reset_n <= 1'b0;
            halted       <= 1'b1;
            train_start  <= 1'b0;
            train_count  <= '0;
        end else begin
            state <= state_next;
            if (dly != DLY_MAX) dly <= dly + 1'b1;
            if (state == PSEQ_RESET_HOLD && state_next == PSEQ_START_WAIT) core_reset_n <= 1'b1;
            halted      <= is_idle(state_next);
            train_start <= !clear && (load0 || last);
            if (last) train_count <= train_count + 32'd1;
        end
    end

endmodule
